serial_add_ctrl: RTL

Bit-serial add/subtract controller that time-shares a single one-bit full-adder cell across a WIDTH-bit operation. It accepts an operand pair with a start pulse and feeds the cell one bit per clock, LSB first, through the registered carry. It assembles the result and reports sum, carry-out and signed overflow with a done pulse. It sits between a requesting controller and the one-bit full-adder datapath, replacing a WIDTH-bit parallel adder where area matters more than latency.

---
 rtl/serial_add_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract using one full-adder cell, LSB first
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_cin_msb;
  logic             w_s, w_co, w_last;
  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_co   = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_c       <= 1'b0;
      r_cin_msb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_c     <= sub;
          r_cnt   <= '0;
          busy    <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          r_res <= {w_s, r_res[WIDTH-1:1]};
          r_c   <= w_co;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 2)) r_cin_msb <= w_co;
          if (w_last) begin
            sum     <= {w_s, r_res[WIDTH-1:1]};
            cout    <= w_co;
            // the carry entering the MSB is the live carry register on this edge
            ovf     <= r_c ^ w_co;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
